// File: rtl/user_ip_apb_mux_if.sv
// APB4 bus bundle (32-bit address and data) shared by the host side and by
// every user IP slot port of user_ip_apb_mux.
//   master modport : drives the request (paddr/psel/penable/pwrite/pwdata/pstrb/pprot)
//                    and receives the response (prdata/pready/pslverr)
//   slave modport  : the mirror image
interface apb4_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/user_ip_apb_mux.sv
// Registered APB4 fan-out from the SoC peripheral bus to SLOT_NUM user IP
// slots. The host address field paddr[SLOT_LSB+3:SLOT_LSB] selects a slot;
// the transfer is replayed on that slot one registered cycle later and the
// slot response is returned to the host in a single-cycle DONE state.
// Accesses to absent slots and to slots that never answer within
// TIMEOUT_CYC access cycles are terminated with pslverr so the host bus
// can never hang.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   apb_s    : host-side APB4 slave port
//   apb_m    : one APB4 master port per user IP slot
//   to_irq_o : one-cycle pulse, coincident with DONE, on each timeout
module user_ip_apb_mux #(
  parameter int unsigned SLOT_NUM    = 4,
  parameter int unsigned SLOT_LSB    = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic   clk_i,
  input  logic   rst_i,
  apb4_if.slave  apb_s,
  apb4_if.master apb_m [SLOT_NUM],
  output logic   to_irq_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t              state_q;
  logic [31:0]         paddr_q;
  logic [31:0]         pwdata_q;
  logic                pwrite_q;
  logic [3:0]          pstrb_q;
  logic [2:0]          pprot_q;
  logic [3:0]          slot_q;
  logic [SLOT_NUM-1:0] psel_q;
  logic [SLOT_NUM-1:0] penable_q;
  logic [31:0]         prdata_q;
  logic                pslverr_q;
  logic                pready_q;
  logic                irq_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [3:0]          req_slot;
  logic                req_in_range;
  logic [SLOT_NUM-1:0] psel_d;

  // Slot responses gathered into 16-entry arrays so the 4-bit slot index
  // can address them directly; unpopulated entries read as zero.
  logic [15:0]         slv_rdy;
  logic [15:0]         slv_err;
  logic [31:0]         slv_rdata [16];
  logic                cur_rdy;
  logic                cur_err;
  logic [31:0]         cur_rdata;

  assign req_slot     = apb_s.paddr[SLOT_LSB+3 -: 4];
  assign req_in_range = (32'(req_slot) < SLOT_NUM);

  always_comb begin
    psel_d = '0;
    for (int unsigned i = 0; i < SLOT_NUM; i++) begin
      psel_d[i] = (32'(req_slot) == i);
    end
  end

  generate
    for (genvar g = 0; g < 16; g++) begin : g_slot
      if (g < SLOT_NUM) begin : g_used
        assign slv_rdy[g]       = apb_m[g].pready;
        assign slv_err[g]       = apb_m[g].pslverr;
        assign slv_rdata[g]     = apb_m[g].prdata;
        assign apb_m[g].psel    = psel_q[g];
        assign apb_m[g].penable = penable_q[g];
        assign apb_m[g].paddr   = paddr_q;
        assign apb_m[g].pwrite  = pwrite_q;
        assign apb_m[g].pwdata  = pwdata_q;
        assign apb_m[g].pstrb   = pstrb_q;
        assign apb_m[g].pprot   = pprot_q;
      end else begin : g_unused
        assign slv_rdy[g]   = 1'b0;
        assign slv_err[g]   = 1'b0;
        assign slv_rdata[g] = '0;
      end
    end
  endgenerate

  assign cur_rdy   = slv_rdy[slot_q];
  assign cur_err   = slv_err[slot_q];
  assign cur_rdata = slv_rdata[slot_q];

  assign apb_s.pready  = pready_q;
  assign apb_s.prdata  = prdata_q;
  assign apb_s.pslverr = pslverr_q;
  assign to_irq_o      = irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      slot_q    <= '0;
      psel_q    <= '0;
      penable_q <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      pready_q  <= 1'b0;
      irq_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pready_q <= 1'b0;
      irq_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (apb_s.psel && !apb_s.penable) begin
            paddr_q  <= apb_s.paddr;
            pwrite_q <= apb_s.pwrite;
            pwdata_q <= apb_s.pwdata;
            pstrb_q  <= apb_s.pstrb;
            pprot_q  <= apb_s.pprot;
            slot_q   <= req_slot;
            if (req_in_range) begin
              state_q <= SETUP;
              psel_q  <= psel_d;
            end else begin
              state_q   <= DONE;
              prdata_q  <= '0;
              pslverr_q <= 1'b1;
              pready_q  <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= psel_q;
          cnt_q     <= '0;
        end
        ACCESS: begin
          // cnt_q holds the number of ACCESS cycles already spent, so the
          // TIMEOUT_CYC-th cycle is the one where it equals TIMEOUT_CYC-1;
          // a pready in that same cycle still wins.
          if (cur_rdy) begin
            state_q   <= DONE;
            prdata_q  <= pwrite_q ? '0 : cur_rdata;
            pslverr_q <= cur_err;
            pready_q  <= 1'b1;
            psel_q    <= '0;
            penable_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= DONE;
            prdata_q  <= '0;
            pslverr_q <= 1'b1;
            pready_q  <= 1'b1;
            irq_q     <= 1'b1;
            psel_q    <= '0;
            penable_q <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // Response registers return to zero so the host outputs are only
          // non-zero while pready is high.
          state_q   <= IDLE;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
